alu_exec_unit: RTL

- Execute-stage consumer of the ALU decode outputs (ALUControl, BranchOp, SLTc): computes the arithmetic/logic result, SLT/SLTU result and branch-taken flag.
- Sits in EX between the ID/EX operand register and the EX/MEM register.
- Valid/ready handshakes on both sides; iterative multi-cycle shifter.
- One operation in flight at a time.

---
 rtl/alu_exec_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU / compare / branch-resolve unit with valid/ready
// handshakes on both sides and one operation in flight.
// Optional build macro: ALU_EXEC_FAST_SHIFT_EN
//   defined   -> single-cycle barrel shifter, SHIFT state not built, latency 1
//   undefined -> iterative one-bit-per-cycle shifter, latency shamt+1
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a new operation (in_ready=1)
// S_SHIFT | iterative shift in progress, down-counter holds bits left
// S_DONE  | result/zero/branch_taken held, out_valid=1, wait out_ready
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      alu_ctrl,
    input  logic [1:0]      branch_op,
    input  logic            slt_c,
    input  logic            arith,
    input  logic            is_branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DONE  = 2'd2
`ifndef ALU_EXEC_FAST_SHIFT_EN
        ,
        S_SHIFT = 2'd1
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_branch_taken;

    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_diff;
    logic              w_lt;
    logic              w_zero;
    logic              w_taken;
    logic [SHW-1:0]    w_shamt;
    logic              w_is_shift;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN-1:0]   w_result;
    logic              w_accept;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    logic [XLEN-1:0]   w_sra;
`else
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]   r_shreg;
    logic [SHW-1:0]    r_cnt;
    logic              r_shift_left;
    logic              r_fill;
    logic              r_slt_c;
    logic [XLEN-1:0]   w_shreg_next;
    logic              w_iter_start;
`endif

    assign w_sum      = op_a + op_b;
    assign w_diff     = op_a - op_b;
    assign w_zero     = (op_a == op_b);
    assign w_shamt    = op_b[SHW-1:0];
    assign w_is_shift = (alu_ctrl == 3'b010) || (alu_ctrl == 3'b100);
    assign w_accept   = in_valid && (r_state == S_IDLE);

`ifdef ALU_EXEC_FAST_SHIFT_EN
    // Kept apart from the result mux so the arithmetic shift stays signed.
    assign w_sra = $unsigned($signed(op_a) >>> w_shamt);
`else
    assign w_iter_start = w_accept && w_is_shift && (w_shamt != '0);
    assign w_shreg_next = r_shift_left ? {r_shreg[XLEN-2:0], 1'b0}
                                       : {r_fill, r_shreg[XLEN-1:1]};
`endif

    // Compare bit, raw ALU output and branch outcome from the live operands.
    always_comb begin
        w_lt = 1'b0;
        case (alu_ctrl)
            3'b001:  w_lt = ($signed(op_a) < $signed(op_b));
            3'b011:  w_lt = (op_a < op_b);
            default: w_lt = 1'b0;
        endcase

        w_alu = '0;
        case (alu_ctrl)
            3'b000:  w_alu = w_sum;
            3'b001:  w_alu = w_diff;
            3'b011:  w_alu = w_diff;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            3'b010:  w_alu = op_a << w_shamt;
            3'b100:  w_alu = arith ? w_sra : (op_a >> w_shamt);
`else
            // Iterative build: only the shamt=0 case takes this path.
            3'b010:  w_alu = op_a;
            3'b100:  w_alu = op_a;
`endif
            3'b101:  w_alu = op_a ^ op_b;
            3'b110:  w_alu = op_a | op_b;
            3'b111:  w_alu = op_a & op_b;
            default: w_alu = '0;
        endcase

        w_result = slt_c ? {{(XLEN-1){1'b0}}, w_lt} : w_alu;

        w_taken = 1'b0;
        if (is_branch) begin
            case (branch_op)
                2'b00:   w_taken = w_zero;
                2'b01:   w_taken = !w_zero;
                2'b10:   w_taken = w_lt;
                default: w_taken = !w_lt;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
                    w_state_next = S_DONE;
`else
                    w_state_next = w_iter_start ? S_SHIFT : S_DONE;
`endif
                end
            end
`ifndef ALU_EXEC_FAST_SHIFT_EN
            S_SHIFT: begin
                if (r_cnt == CNT_ONE) w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output registers: flags captured at accept, result at accept or shift end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result       <= '0;
            r_zero         <= 1'b0;
            r_branch_taken <= 1'b0;
        end else if (w_accept) begin
            r_zero         <= w_zero;
            r_branch_taken <= w_taken;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            r_result       <= w_result;
`else
            if (!w_iter_start) r_result <= w_result;
`endif
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        else if ((r_state == S_SHIFT) && (r_cnt == CNT_ONE)) begin
            // Shift ops never compare, so an SLT view of them reads as 0.
            r_result <= r_slt_c ? '0 : w_shreg_next;
        end
`endif
    end

`ifndef ALU_EXEC_FAST_SHIFT_EN
    // Iterative shifter: shift register plus shift-amount down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_shift_left <= 1'b0;
            r_fill       <= 1'b0;
            r_slt_c      <= 1'b0;
        end else if (w_iter_start) begin
            r_shreg      <= op_a;
            r_cnt        <= w_shamt;
            r_shift_left <= (alu_ctrl == 3'b010);
            r_fill       <= (alu_ctrl == 3'b100) && arith && op_a[XLEN-1];
            r_slt_c      <= slt_c;
        end else if (r_state == S_SHIFT) begin
            r_shreg      <= w_shreg_next;
            r_cnt        <= r_cnt - CNT_ONE;
        end
    end
`endif

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign zero         = r_zero;
    assign branch_taken = r_branch_taken;

endmodule
